serial_word_collector: RTL

- Upstream stage of the 7-bit combinational word checker. It deserializes a strobed serial bit stream into WIDTH-bit parallel words.
- Each completed word is presented on a held-stable bus with a valid/ready handshake, so the checker's 7-bit input sees only complete, stable frames.
- Frame errors and overruns are flagged as sticky status bits.

---
 rtl/serial_word_collector_pkg.sv | 18 +
 rtl/serial_word_collector_sipo_shift_reg.sv | 33 +++
 rtl/serial_word_collector.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for the serial word collector: FSM state encoding,
// the default frame width shared with the downstream checker, and counter sizing.
package serial_word_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 7;

    // One extra bit of headroom so WIDTH-1 is always representable.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_word_collector_sipo_shift_reg.sv
// Serial-in parallel-out shift register; load_first starts a new frame
// with din in the position from which WIDTH-1 further shifts carry it to its final bit.
module sipo_shift_reg #(
    parameter int WIDTH     = 7,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             load_first,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load_first) begin
            if (MSB_FIRST != 0) begin
                q <= {{(WIDTH-1){1'b0}}, din};
            end else begin
                q <= {din, {(WIDTH-1){1'b0}}};
            end
        end else if (shift_en) begin
            if (MSB_FIRST != 0) begin
                q <= (q << 1) | {{(WIDTH-1){1'b0}}, din};
            end else begin
                q <= (q >> 1) | {din, {(WIDTH-1){1'b0}}};
            end
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// Deserialises a strobed bit stream into WIDTH-bit words held on a valid/ready
// bus, with sticky overrun and frame-error status.
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             ser_start,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] shifted;
    logic             shift_en;
    logic             load_first;
    logic             word_load;
    logic             valid_d;
    logic             set_ovr;
    logic             set_ferr;
    logic             handshake;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (shift_en),
        .load_first (load_first),
        .din        (ser_in),
        .q          (sr_q)
    );

    // The last bit is merged here so the word is complete on the same edge it arrives.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = (sr_q << 1) | {{(WIDTH-1){1'b0}}, ser_in};
        end else begin
            shifted = (sr_q >> 1) | {ser_in, {(WIDTH-1){1'b0}}};
        end
    end

    assign handshake = word_valid & word_ready;
    assign busy      = (state_q == ST_SHIFT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_en   = 1'b0;
        load_first = 1'b0;
        word_load  = 1'b0;
        valid_d    = word_valid;
        set_ovr    = 1'b0;
        set_ferr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ser_valid && ser_start) begin
                    load_first = 1'b1;
                    cnt_d      = CW'(1);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ser_valid) begin
                    if (ser_start) begin
                        load_first = 1'b1;
                        cnt_d      = CW'(1);
                        set_ferr   = 1'b1;
                    end else if (cnt_q == CW'(WIDTH - 1)) begin
                        shift_en  = 1'b1;
                        word_load = 1'b1;
                        valid_d   = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_HOLD;
                    end else begin
                        shift_en = 1'b1;
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                    // A start bit riding on the handshake opens the next frame immediately.
                    if (ser_valid && ser_start) begin
                        load_first = 1'b1;
                        cnt_d      = CW'(1);
                        state_d    = ST_SHIFT;
                    end else if (ser_valid) begin
                        set_ovr = 1'b1;
                    end
                end else if (ser_valid) begin
                    set_ovr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_valid <= valid_d;
            if (word_load) begin
                word <= shifted;
            end
            overrun   <= set_ovr  | (overrun   & ~clr_err);
            frame_err <= set_ferr | (frame_err & ~clr_err);
        end
    end

endmodule
